// File: rtl/key_entry_buffer_pkg.sv
// Keypad code constants, FSM states and decoded-key bundle
// shared by the key entry buffer and its code decoder.
package key_entry_buffer_pkg;

  localparam logic [7:0] KEY_NONE = 8'h00;
  localparam logic [7:0] KEY_0    = 8'hA0;
  localparam logic [7:0] KEY_1    = 8'h01;
  localparam logic [7:0] KEY_2    = 8'h02;
  localparam logic [7:0] KEY_3    = 8'h04;
  localparam logic [7:0] KEY_4    = 8'h08;
  localparam logic [7:0] KEY_5    = 8'h10;
  localparam logic [7:0] KEY_6    = 8'h20;
  localparam logic [7:0] KEY_7    = 8'h40;
  localparam logic [7:0] KEY_8    = 8'h80;
  localparam logic [7:0] KEY_9    = 8'h90;
  localparam logic [7:0] KEY_STAR = 8'hB0;
  localparam logic [7:0] KEY_HASH = 8'hC0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DEBOUNCE,
    ST_ACCEPT,
    ST_HELD,
    ST_RELEASE
  } state_t;

  typedef struct packed {
    logic       is_digit;
    logic       is_star;
    logic       is_hash;
    logic       is_bad;
    logic [3:0] digit;
  } key_info_t;

endpackage

// File: rtl/key_code_decode.sv
// Combinational keypad code classifier: digit value,
// clear, commit, or invalid code.
module key_code_decode
  import key_entry_buffer_pkg::*;
(
  input  logic [7:0] code,
  output key_info_t  info
);

  always_comb begin
    info = '0;
    unique case (code)
      KEY_NONE: ;
      KEY_0: begin info.is_digit = 1'b1; info.digit = 4'd0; end
      KEY_1: begin info.is_digit = 1'b1; info.digit = 4'd1; end
      KEY_2: begin info.is_digit = 1'b1; info.digit = 4'd2; end
      KEY_3: begin info.is_digit = 1'b1; info.digit = 4'd3; end
      KEY_4: begin info.is_digit = 1'b1; info.digit = 4'd4; end
      KEY_5: begin info.is_digit = 1'b1; info.digit = 4'd5; end
      KEY_6: begin info.is_digit = 1'b1; info.digit = 4'd6; end
      KEY_7: begin info.is_digit = 1'b1; info.digit = 4'd7; end
      KEY_8: begin info.is_digit = 1'b1; info.digit = 4'd8; end
      KEY_9: begin info.is_digit = 1'b1; info.digit = 4'd9; end
      KEY_STAR: info.is_star = 1'b1;
      KEY_HASH: info.is_hash = 1'b1;
      default:  info.is_bad  = 1'b1;
    endcase
  end

endmodule

// File: rtl/key_entry_buffer.sv
// Debounces keypad codes and accumulates digits into a BCD
// entry buffer; '*' clears it, '#' commits it to entry_value.
module key_entry_buffer
  import key_entry_buffer_pkg::*;
#(
  parameter int DIGITS     = 4,
  parameter int STABLE_CNT = 50000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            key_data,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [3:0]            digit_cnt,
  output logic [4*DIGITS-1:0]   entry_value,
  output logic                  enter_pulse,
  output logic                  ovf_pulse,
  output logic                  err_pulse
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = (STABLE_CNT > 2) ? $clog2(STABLE_CNT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CNT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [3:0]    FULL     = 4'(DIGITS);

  logic [7:0]    key_q;
  logic [7:0]    cand;
  logic [CW-1:0] cnt;
  state_t        state;
  key_info_t     info;
  logic [BW+3:0] shifted;

  // The action is taken from the debounced candidate, not the live code.
  key_code_decode u_decode (
    .code (cand),
    .info (info)
  );

  assign shifted = {bcd, info.digit};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_q       <= KEY_NONE;
      cand        <= KEY_NONE;
      cnt         <= '0;
      state       <= ST_IDLE;
      bcd         <= '0;
      digit_cnt   <= '0;
      entry_value <= '0;
      enter_pulse <= 1'b0;
      ovf_pulse   <= 1'b0;
      err_pulse   <= 1'b0;
    end else begin
      key_q       <= key_data;
      enter_pulse <= 1'b0;
      ovf_pulse   <= 1'b0;
      err_pulse   <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (key_q != KEY_NONE) begin
            state <= ST_DEBOUNCE;
            cand  <= key_q;
            cnt   <= CNT_ONE;
          end
        end
        ST_DEBOUNCE: begin
          if (key_q == KEY_NONE) begin
            state <= ST_IDLE;
          end else if (key_q != cand) begin
            cand <= key_q;
            cnt  <= CNT_ONE;
          end else if (cnt == CNT_LAST) begin
            state <= ST_ACCEPT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_ACCEPT: begin
          state <= ST_HELD;
          unique case (1'b1)
            info.is_digit: begin
              if (digit_cnt < FULL) begin
                bcd       <= shifted[BW-1:0];
                digit_cnt <= digit_cnt + 4'd1;
              end else begin
                ovf_pulse <= 1'b1;
              end
            end
            info.is_star: begin
              bcd       <= '0;
              digit_cnt <= '0;
            end
            info.is_hash: begin
              entry_value <= bcd;
              enter_pulse <= 1'b1;
              bcd         <= '0;
              digit_cnt   <= '0;
            end
            info.is_bad: err_pulse <= 1'b1;
            default: ;
          endcase
        end
        // No auto-repeat: anything held is ignored until a stable release.
        ST_HELD: begin
          if (key_q == KEY_NONE) begin
            state <= ST_RELEASE;
            cnt   <= CNT_ONE;
          end
        end
        ST_RELEASE: begin
          if (key_q != KEY_NONE) begin
            state <= ST_HELD;
          end else if (cnt == CNT_LAST) begin
            state <= ST_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_key_entry_buffer.sv
// Scoreboard bench for key_entry_buffer with DIGITS=4,
// STABLE_CNT=4: expected actions queued, observed actions popped.
module tb_key_entry_buffer;

  typedef struct packed {
    logic [15:0] bcd;
    logic [3:0]  cnt;
    logic [15:0] entry;
    logic        enter;
    logic        ovf;
    logic        err;
  } ev_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  key_data = 8'h00;
  logic [15:0] bcd;
  logic [3:0]  digit_cnt;
  logic [15:0] entry_value;
  logic        enter_pulse;
  logic        ovf_pulse;
  logic        err_pulse;

  ev_t exp_q[$];
  ev_t obs_q[$];
  int  obs_cyc[$];
  ev_t snap, prev, e, o;
  int  checks = 0;
  int  failures = 0;
  int  cyc = 0;
  logic mon_en = 1'b0;

  key_entry_buffer #(.DIGITS(4), .STABLE_CNT(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .key_data    (key_data),
    .bcd         (bcd),
    .digit_cnt   (digit_cnt),
    .entry_value (entry_value),
    .enter_pulse (enter_pulse),
    .ovf_pulse   (ovf_pulse),
    .err_pulse   (err_pulse)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // An action is any change of the held values or any strobe.
  always @(negedge clk) begin
    snap = {bcd, digit_cnt, entry_value, enter_pulse, ovf_pulse, err_pulse};
    if (mon_en && ({snap.bcd, snap.cnt, snap.entry} !== {prev.bcd, prev.cnt, prev.entry}
        || snap.enter || snap.ovf || snap.err)) begin
      obs_q.push_back(snap);
      obs_cyc.push_back(cyc);
    end
    prev = snap;
  end

  function automatic ev_t ev(logic [15:0] b, logic [3:0] c, logic [15:0] en, logic [2:0] p);
    return {b, c, en, p};
  endfunction

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(logic [7:0] code, int hold = 10, int rel = 10);
    key_data = code;
    step(hold);
    key_data = 8'h00;
    step(rel);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    step(3);
    checks++;
    if ({bcd, digit_cnt, entry_value, enter_pulse, ovf_pulse, err_pulse} !== 39'd0) begin
      failures++;
      $display("FAIL reset_state got %h want 0",
               {bcd, digit_cnt, entry_value, enter_pulse, ovf_pulse, err_pulse});
    end
    reset = 1'b0;
    step(2);
    mon_en = 1'b1;
  endtask

  task automatic test_single;
    int t0;
    exp_q.push_back(ev(16'h0002, 4'd1, 16'h0, 3'b000));
    t0 = cyc + 1;
    press(8'h02);
    checks++;
    if (obs_cyc.size() == 0 || obs_cyc[0] - t0 != 5) begin
      failures++;
      $display("FAIL single_latency got %0d want 5",
               obs_cyc.size() ? obs_cyc[0] - t0 : -1);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        failures++;
        $display("FAIL single_missing got none want %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          failures++;
          $display("FAIL single_action got %h want %h", o, e);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      failures++;
      $display("FAIL single_extra got %0d want 0", obs_q.size());
    end
    obs_q.delete();
    obs_cyc.delete();
  endtask

  task automatic test_overflow;
    exp_q.push_back(ev(16'h0000, 4'd0, 16'h0, 3'b000));
    exp_q.push_back(ev(16'h0001, 4'd1, 16'h0, 3'b000));
    exp_q.push_back(ev(16'h0012, 4'd2, 16'h0, 3'b000));
    exp_q.push_back(ev(16'h0123, 4'd3, 16'h0, 3'b000));
    exp_q.push_back(ev(16'h1234, 4'd4, 16'h0, 3'b000));
    exp_q.push_back(ev(16'h1234, 4'd4, 16'h0, 3'b010));
    press(8'hB0);
    press(8'h01);
    press(8'h02);
    press(8'h04);
    press(8'h08);
    press(8'h10);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        failures++;
        $display("FAIL overflow_missing got none want %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          failures++;
          $display("FAIL overflow_action got %h want %h", o, e);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      failures++;
      $display("FAIL overflow_extra got %0d want 0", obs_q.size());
    end
    obs_q.delete();
    obs_cyc.delete();
  endtask

  task automatic test_enter;
    exp_q.push_back(ev(16'h0000, 4'd0, 16'h0, 3'b000));
    exp_q.push_back(ev(16'h0009, 4'd1, 16'h0, 3'b000));
    exp_q.push_back(ev(16'h0090, 4'd2, 16'h0, 3'b000));
    exp_q.push_back(ev(16'h0000, 4'd0, 16'h0090, 3'b100));
    press(8'hB0);
    press(8'h90);
    press(8'hA0);
    press(8'hC0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        failures++;
        $display("FAIL enter_missing got none want %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          failures++;
          $display("FAIL enter_action got %h want %h", o, e);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      failures++;
      $display("FAIL enter_extra got %0d want 0", obs_q.size());
    end
    obs_q.delete();
    obs_cyc.delete();
  endtask

  task automatic test_star;
    exp_q.push_back(ev(16'h0007, 4'd1, 16'h0090, 3'b000));
    exp_q.push_back(ev(16'h0000, 4'd0, 16'h0090, 3'b000));
    press(8'h40);
    press(8'hB0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        failures++;
        $display("FAIL star_missing got none want %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          failures++;
          $display("FAIL star_action got %h want %h", o, e);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      failures++;
      $display("FAIL star_extra got %0d want 0", obs_q.size());
    end
    obs_q.delete();
    obs_cyc.delete();
  endtask

  task automatic test_bounce;
    repeat (5) begin
      key_data = 8'h04;
      step(2);
      key_data = 8'h00;
      step(2);
    end
    step(10);
    checks++;
    if (obs_q.size() != 0) begin
      failures++;
      $display("FAIL bounce_quiet got %0d actions want 0", obs_q.size());
    end
    obs_q.delete();
    obs_cyc.delete();
    exp_q.push_back(ev(16'h0003, 4'd1, 16'h0090, 3'b000));
    press(8'h04);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        failures++;
        $display("FAIL bounce_missing got none want %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          failures++;
          $display("FAIL bounce_action got %h want %h", o, e);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      failures++;
      $display("FAIL bounce_extra got %0d want 0", obs_q.size());
    end
    obs_q.delete();
    obs_cyc.delete();
  endtask

  task automatic test_held;
    exp_q.push_back(ev(16'h0031, 4'd2, 16'h0090, 3'b000));
    key_data = 8'h01;
    step(8);
    key_data = 8'h02;
    step(10);
    key_data = 8'h00;
    step(2);
    key_data = 8'h01;
    step(8);
    key_data = 8'h00;
    step(10);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        failures++;
        $display("FAIL held_missing got none want %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          failures++;
          $display("FAIL held_action got %h want %h", o, e);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      failures++;
      $display("FAIL held_extra got %0d want 0", obs_q.size());
    end
    obs_q.delete();
    obs_cyc.delete();
  endtask

  task automatic test_reset_mid;
    exp_q.push_back(ev(16'h0000, 4'd0, 16'h0090, 3'b000));
    exp_q.push_back(ev(16'h0001, 4'd1, 16'h0090, 3'b000));
    exp_q.push_back(ev(16'h0012, 4'd2, 16'h0090, 3'b000));
    press(8'hB0);
    press(8'h01);
    press(8'h02);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        failures++;
        $display("FAIL pre_reset_missing got none want %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          failures++;
          $display("FAIL pre_reset_action got %h want %h", o, e);
        end
      end
    end
    obs_q.delete();
    obs_cyc.delete();
    key_data = 8'h04;
    step(3);
    mon_en = 1'b0;
    reset = 1'b1;
    #1;
    checks++;
    if ({bcd, digit_cnt, entry_value, enter_pulse, ovf_pulse, err_pulse} !== 39'd0) begin
      failures++;
      $display("FAIL reset_async got %h want 0",
               {bcd, digit_cnt, entry_value, enter_pulse, ovf_pulse, err_pulse});
    end
    step(2);
    key_data = 8'h00;
    step(2);
    reset = 1'b0;
    step(2);
    mon_en = 1'b1;
  endtask

  task automatic test_invalid_empty;
    exp_q.push_back(ev(16'h0000, 4'd0, 16'h0000, 3'b001));
    exp_q.push_back(ev(16'h0000, 4'd0, 16'h0000, 3'b100));
    press(8'h03);
    press(8'hC0);
    press(8'hB0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        failures++;
        $display("FAIL invalid_missing got none want %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          failures++;
          $display("FAIL invalid_action got %h want %h", o, e);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      failures++;
      $display("FAIL invalid_extra got %0d want 0", obs_q.size());
    end
    obs_q.delete();
    obs_cyc.delete();
  endtask

  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_enter();
    test_star();
    test_bounce();
    test_held();
    test_reset_mid();
    test_invalid_empty();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
